// File: rtl/bitfield_unit.sv
// Two-stage bit-field extract/insert: S1 registers operands and decoded mask, S2 registers the result (2 edges).
// Backpressure: S2 holds under !out_ready, bubbles collapse, at most two ops buffered before in_ready drops.

module accum_decoder #(
  parameter int N = 6
) (
  input  logic [N-1:0]        len_i,
  output logic [(1<<N)-1:0]   mask_o
);
  // Thermometer mask: bits [len-1:0] set, len = 0 yields an empty mask.
  assign mask_o = ~({(1<<N){1'b1}} << len_i);
endmodule

module bitfield_unit #(
  parameter int XLEN     = 64,
  parameter int LOG_XLEN = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                op,
  input  logic [XLEN-1:0]     src,
  input  logic [XLEN-1:0]     dst,
  input  logic [LOG_XLEN-1:0] pos,
  input  logic [LOG_XLEN-1:0] len,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     result
);

  typedef struct packed {
    logic                op;
    logic [XLEN-1:0]     src;
    logic [XLEN-1:0]     dst;
    logic [LOG_XLEN-1:0] pos;
    logic [XLEN-1:0]     mask;
  } s1_t;

  s1_t             s1_q, s1_d;
  logic            s1_valid_q, s1_valid_d;
  logic            s2_valid_q, s2_valid_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] field;
  logic [XLEN-1:0] field_mask;
  logic [XLEN-1:0] calc;
  logic            s1_adv;
  logic            s1_load;

  accum_decoder #(.N(LOG_XLEN)) u_mask_dec (
    .len_i  (len),
    .mask_o (mask)
  );

  assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !flush && (!s1_valid_q || s1_adv);
  assign s1_load  = in_valid && in_ready;

  // Shifts are XLEN wide, so anything pushed past the MSB simply falls off.
  assign field      = s1_q.src & s1_q.mask;
  assign field_mask = s1_q.mask << s1_q.pos;
  assign calc       = s1_q.op ? ((s1_q.dst & ~field_mask) | (field << s1_q.pos))
                              : ((s1_q.src >> s1_q.pos) & s1_q.mask);

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;

    if (s1_load) begin
      s1_d.op   = op;
      s1_d.src  = src;
      s1_d.dst  = dst;
      s1_d.pos  = pos;
      s1_d.mask = mask;
    end

    if (s1_adv) begin
      result_d = calc;
    end

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_load)     s1_valid_d = 1'b1;
      else if (s1_adv) s1_valid_d = 1'b0;

      if (s1_adv)                       s2_valid_d = 1'b1;
      else if (s2_valid_q && out_ready) s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_bitfield_unit.sv
// Scoreboard bench for bitfield_unit: expectations queued at acceptance, checked when results leave.
module tb_bitfield_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [63:0] src;
  logic [63:0] dst;
  logic [5:0]  pos;
  logic [5:0]  len;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  bitfield_unit #(.XLEN(64), .LOG_XLEN(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src       (src),
    .dst       (dst),
    .pos       (pos),
    .len       (len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic o, input logic [63:0] s, input logic [63:0] d,
                                        input int p, input int l);
    logic [63:0] r;
    r = o ? d : 64'h0;
    for (int i = 0; i < l; i++) begin
      if (p + i < 64) begin
        if (o) r[p+i] = s[i];
        else   r[i]   = s[p+i];
      end
    end
    return r;
  endfunction

  // Results are checked where they transfer: inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected: got result %h with nothing expected", result);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (result !== e) begin
          errors++;
          $display("FAIL scoreboard_result: got %h expected %h", result, e);
        end
      end
    end
  end

  task automatic send(input logic o, input logic [63:0] s, input logic [63:0] d,
                      input logic [5:0] p, input logic [5:0] l, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    op = o; src = s; dst = d; pos = p; len = l; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(o, s, d, int'(p), int'(l)));
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (exp_q.size() != 0); i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 1'b0; src = '0; dst = '0; pos = '0; len = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || result !== 64'h0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b result=%h, required 0 and 0", out_valid, result);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_extract();
    int w;
    out_ready = 1'b1;
    send(1'b0, 64'h0000_0000_00AB_CD00, 64'h0, 6'd8, 6'd16, w);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL extract_early: out_valid=%b one edge after accept, required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || result !== 64'h0000_0000_0000_ABCD) begin
      errors++;
      $display("FAIL extract_latency: out_valid=%b result=%h, required 1 and 000000000000abcd",
               out_valid, result);
    end
    drain();
  endtask

  task automatic test_insert();
    int w;
    send(1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd4, 6'd8, w);
    send(1'b1, 64'h0000_0000_0000_00A5, 64'h1111_2222_3333_4444, 6'd16, 6'd8, w);
    send(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 6'd0, 6'd63, w);
    send(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 6'd0, 6'd63, w);
    drain();
  endtask

  task automatic test_len_zero();
    int w;
    send(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 6'd5, 6'd0, w);
    send(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0, 6'd12, 6'd0, w);
    drain();
  endtask

  task automatic test_truncation();
    int w;
    send(1'b0, 64'hF000_0000_0000_0000, 64'h0, 6'd60, 6'd8, w);
    send(1'b1, 64'h0000_0000_0000_00FF, 64'h0, 6'd60, 6'd8, w);
    send(1'b1, 64'h0000_0000_0000_00FF, 64'h0123_4567_89AB_CDEF, 6'd62, 6'd5, w);
    drain();
  endtask

  task automatic test_back_to_back();
    int w;
    int total;
    total = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(i[0], {$urandom, $urandom}, {$urandom, $urandom},
           6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), w);
      total += w;
    end
    checks++;
    if (total != 0) begin
      errors++;
      $display("FAIL back_to_back_stalls: %0d stall cycles, required 0", total);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int w;
    logic [63:0] exp_a;
    out_ready = 1'b0;
    exp_a = model(1'b0, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 4, 12);
    send(1'b0, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 6'd4, 6'd12, w);
    send(1'b0, 64'h0123_4567_89AB_CDEF, 64'h0, 6'd20, 6'd20, w);
    op = 1'b0; src = 64'hAAAA_5555_AAAA_5555; dst = '0; pos = 6'd1; len = 6'd33;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== exp_a) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: in_ready=%b out_valid=%b result=%h, required 0 1 %h",
                 i, in_ready, out_valid, result, exp_a);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: in_ready=%b required 1", in_ready);
    end else begin
      exp_q.push_back(model(1'b0, 64'hAAAA_5555_AAAA_5555, 64'h0, 1, 33));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_stream[%0d]: out_valid=%b required 1", i, out_valid);
      end
      @(posedge clk); #1;
    end
    drain();
  endtask

  task automatic test_flush();
    int w;
    out_ready = 1'b0;
    send(1'b0, 64'h1111_1111_1111_1111, 64'h0, 6'd0, 6'd8, w);
    send(1'b1, 64'h2222_2222_2222_2222, 64'h0, 6'd8, 6'd8, w);
    flush = 1'b1;
    in_valid = 1'b1; op = 1'b0; src = 64'hFFFF; dst = '0; pos = '0; len = 6'd4;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_ready: got %b required 0", in_ready);
    end
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL flush_empty[%0d]: out_valid=%b in_ready=%b, required 0 1", i, out_valid, in_ready);
      end
      @(posedge clk); #1;
    end
    send(1'b1, 64'h0000_0000_0000_000C, 64'hFFFF_0000_FFFF_0000, 6'd30, 6'd4, w);
    drain();
  endtask

  task automatic test_reset_midstream();
    int w;
    out_ready = 1'b0;
    send(1'b0, 64'h5555_5555_5555_5555, 64'h0, 6'd2, 6'd10, w);
    send(1'b1, 64'hFF, 64'h0, 6'd2, 6'd10, w);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 64'h0) begin
      errors++;
      $display("FAIL reset_async: out_valid=%b result=%h, required 0 and 0", out_valid, result);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_ghost[%0d]: out_valid=%b in_ready=%b, required 0 1", i, out_valid, in_ready);
      end
      @(posedge clk); #1;
    end
    send(1'b0, 64'h8000_0000_0000_0001, 64'h0, 6'd63, 6'd1, w);
    drain();
  endtask

  initial begin
    test_reset();
    test_extract();
    test_insert();
    test_len_zero();
    test_truncation();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
